// File: rtl/hdmi_out_pkg.sv
// rtl/hdmi_out_pkg.sv - shared state encodings and defaults for the hdmi_out blocks
package hdmi_out_pkg;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_RUN     = 2'd1,
    ST_PENDING = 2'd2
  } fb_state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

endpackage

// File: rtl/fb_swap_ctrl_if.sv
// rtl/fb_swap_ctrl_if.sv - command, vsync and status signals of the frame-buffer swap controller
interface fb_swap_ctrl_if #(
  parameter int AW = 32,
  parameter int CW = 16,
  parameter int DW = 8
);
  logic          enable_I;
  logic          disable_I;
  logic          swap_I;
  logic [AW-1:0] addr_I;
  logic          vsync_I;
  logic [AW-1:0] base_addr_O;
  logic          active_O;
  logic          swap_pending_O;
  logic          swap_done_O;
  logic          frame_start_O;
  logic [CW-1:0] frame_cnt_O;
  logic [DW-1:0] drop_cnt_O;

  modport master (
    output enable_I, disable_I, swap_I, addr_I, vsync_I,
    input  base_addr_O, active_O, swap_pending_O, swap_done_O,
           frame_start_O, frame_cnt_O, drop_cnt_O
  );

  modport slave (
    input  enable_I, disable_I, swap_I, addr_I, vsync_I,
    output base_addr_O, active_O, swap_pending_O, swap_done_O,
           frame_start_O, frame_cnt_O, drop_cnt_O
  );
endinterface

// File: rtl/vsync_edge_det.sv
// rtl/vsync_edge_det.sv - leading-edge detector for a sync/enable level of polarity POL
module vsync_edge_det #(
  parameter bit POL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);
  logic prev;

  // History starts inactive so a sync already asserted out of reset counts as an edge.
  always_ff @(posedge clk) begin
    if (rst) prev <= ~POL;
    else     prev <= sig;
  end

  assign rise = (sig == POL) && (prev != POL);
endmodule

// File: rtl/fb_swap_ctrl.sv
// rtl/fb_swap_ctrl.sv - applies enable/disable/swap commands to the scan-out path at vsync-safe instants
module fb_swap_ctrl
  import hdmi_out_pkg::*;
#(
  parameter int            AW         = 32,
  parameter int            CW         = 16,
  parameter int            DW         = 8,
  parameter bit            VSYNC_POL  = 1'b1,
  parameter logic [AW-1:0] RESET_ADDR = AW'(DEFAULT_BASE_ADDR)
) (
  input logic           clk,
  input logic           rst,
  fb_swap_ctrl_if.slave bus
);
  fb_state_t     state, state_n;
  logic [AW-1:0] base_q, base_n, shadow_q, shadow_n;
  logic          done_q, done_n, fs_q, fs_n;
  logic [CW-1:0] fcnt_q, fcnt_n;
  logic [DW-1:0] drop_q, drop_n;
  logic          vs_edge;
  logic          drop_inc;

  vsync_edge_det #(.POL(VSYNC_POL)) u_vs_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (bus.vsync_I),
    .rise (vs_edge)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_OFF;
      base_q   <= RESET_ADDR;
      shadow_q <= '0;
      done_q   <= 1'b0;
      fs_q     <= 1'b0;
      fcnt_q   <= '0;
      drop_q   <= '0;
    end else begin
      state    <= state_n;
      base_q   <= base_n;
      shadow_q <= shadow_n;
      done_q   <= done_n;
      fs_q     <= fs_n;
      fcnt_q   <= fcnt_n;
      drop_q   <= drop_n;
    end
  end

  always_comb begin
    state_n  = state;
    base_n   = base_q;
    shadow_n = shadow_q;
    done_n   = 1'b0;
    fs_n     = 1'b0;
    fcnt_n   = fcnt_q;
    drop_inc = 1'b0;
    unique case (state)
      ST_OFF: begin
        // Not scanning, so a swap is safe to apply right away.
        if (bus.swap_I) begin
          base_n = bus.addr_I;
          done_n = 1'b1;
        end
        if (bus.enable_I && !bus.disable_I) begin
          state_n = ST_RUN;
          fcnt_n  = '0;
        end
      end
      ST_RUN, ST_PENDING: begin
        if (bus.disable_I) begin
          state_n  = ST_OFF;
          drop_inc = bus.swap_I;
        end else begin
          if (vs_edge) begin
            fs_n   = 1'b1;
            fcnt_n = fcnt_q + 1'b1;
            if (state == ST_PENDING) begin
              base_n  = shadow_q;
              done_n  = 1'b1;
              state_n = ST_RUN;
            end
          end
          // A swap landing on the applying edge re-arms without counting as a drop.
          if (bus.swap_I) begin
            shadow_n = bus.addr_I;
            state_n  = ST_PENDING;
            drop_inc = (state == ST_PENDING) && !vs_edge;
          end
        end
      end
      default: state_n = ST_OFF;
    endcase
    drop_n = (drop_inc && drop_q != '1) ? drop_q + 1'b1 : drop_q;
  end

  assign bus.base_addr_O    = base_q;
  assign bus.active_O       = (state == ST_RUN) || (state == ST_PENDING);
  assign bus.swap_pending_O = (state == ST_PENDING);
  assign bus.swap_done_O    = done_q;
  assign bus.frame_start_O  = fs_q;
  assign bus.frame_cnt_O    = fcnt_q;
  assign bus.drop_cnt_O     = drop_q;
endmodule

// File: tb/tb_fb_swap_ctrl.sv
// tb/tb_fb_swap_ctrl.sv - randomized and directed bench for fb_swap_ctrl against a queue-based model
module tb_fb_swap_ctrl;
  localparam int AW = 32;
  localparam int CW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  fb_swap_ctrl_if #(.AW(AW), .CW(CW), .DW(DW)) bus ();

  fb_swap_ctrl #(.AW(AW), .CW(CW), .DW(DW), .VSYNC_POL(1'b1), .RESET_ADDR('0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: on/off flag plus a pending queue that may hold at most one address.
  bit            m_on;
  logic [AW-1:0] m_pend[$];
  logic [AW-1:0] m_base;
  logic [CW-1:0] m_fcnt;
  int            m_drop;
  bit            m_done, m_fs, m_vs_prev;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clock(input bit r, input bit en, input bit dis, input bit sw,
                             input logic [AW-1:0] addr, input bit vs);
    bit edge_seen;
    if (r) begin
      m_on = 0; m_pend.delete(); m_base = '0; m_fcnt = '0; m_drop = 0;
      m_done = 0; m_fs = 0; m_vs_prev = 0;
      return;
    end
    edge_seen = vs && !m_vs_prev;
    m_vs_prev = vs;
    m_done = 0;
    m_fs   = 0;
    if (!m_on) begin
      if (sw) begin m_base = addr; m_done = 1; end
      if (en && !dis) begin m_on = 1; m_fcnt = '0; end
    end else if (dis) begin
      m_on = 0;
      m_pend.delete();
      if (sw && m_drop < 255) m_drop++;
    end else begin
      if (edge_seen) begin
        m_fs = 1;
        m_fcnt = m_fcnt + 1'b1;
        if (m_pend.size() != 0) begin m_base = m_pend.pop_front(); m_done = 1; end
      end
      if (sw) begin
        if (m_pend.size() != 0) begin
          void'(m_pend.pop_front());
          if (m_drop < 255) m_drop++;
        end
        m_pend.push_back(addr);
      end
    end
  endtask

  task automatic check_all();
    check("base_addr", bus.base_addr_O, m_base);
    check("active", bus.active_O, m_on);
    check("swap_pending", bus.swap_pending_O, m_on && m_pend.size() != 0);
    check("swap_done", bus.swap_done_O, m_done);
    check("frame_start", bus.frame_start_O, m_fs);
    check("frame_cnt", bus.frame_cnt_O, m_fcnt);
    check("drop_cnt", bus.drop_cnt_O, m_drop);
  endtask

  task automatic step(input bit r, input bit en, input bit dis, input bit sw,
                      input logic [AW-1:0] addr, input bit vs);
    @(negedge clk);
    rst = r; bus.enable_I = en; bus.disable_I = dis; bus.swap_I = sw;
    bus.addr_I = addr; bus.vsync_I = vs;
    @(posedge clk);
    model_clock(r, en, dis, sw, addr, vs);
    #1 check_all();
  endtask

  task automatic idle(input int n, input bit vs);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, vs);
  endtask

  task automatic vs_pulse();
    step(0, 0, 0, 0, '0, 1);
    step(0, 0, 0, 0, '0, 0);
  endtask

  initial begin
    bit vs;
    step(1, 0, 0, 0, '0, 0);
    step(1, 0, 0, 0, '0, 0);
    check("reset_base", bus.base_addr_O, 0);
    check("reset_active", bus.active_O, 0);

    // Swap while off applies immediately.
    step(0, 0, 0, 1, 32'h1000_0000, 0);
    check("off_swap_base", bus.base_addr_O, 32'h1000_0000);
    check("off_swap_done", bus.swap_done_O, 1);
    idle(1, 0);

    // Pending swap waits for the vsync leading edge.
    step(0, 1, 0, 0, '0, 0);
    step(0, 0, 0, 1, 32'h2000_0000, 0);
    idle(10, 0);
    step(0, 0, 0, 0, '0, 1);
    check("edge_base", bus.base_addr_O, 32'h2000_0000);
    check("edge_fcnt", bus.frame_cnt_O, 1);
    step(0, 0, 0, 0, '0, 0);

    // Three swaps before one edge: last wins, two drops.
    step(0, 0, 0, 1, 32'hA000_0000, 0);
    step(0, 0, 0, 1, 32'hB000_0000, 0);
    step(0, 0, 0, 1, 32'hC000_0000, 0);
    vs_pulse();
    check("last_wins", bus.base_addr_O, 32'hC000_0000);
    check("drop_two", bus.drop_cnt_O, 2);
    for (int i = 0; i < 301; i++) step(0, 0, 0, 1, 32'h3000_0000 + i, 0);
    check("drop_sat", bus.drop_cnt_O, 255);
    vs_pulse();

    // Swap coinciding with the applying edge.
    step(0, 0, 0, 1, 32'hAAAA_0000, 0);
    step(0, 0, 0, 1, 32'hBBBB_0000, 1);
    check("coinc_base", bus.base_addr_O, 32'hAAAA_0000);
    check("coinc_pending", bus.swap_pending_O, 1);
    step(0, 0, 0, 0, '0, 0);
    vs_pulse();
    check("coinc_next", bus.base_addr_O, 32'hBBBB_0000);

    // Disable discards the pending swap; enable+disable stays off.
    step(0, 0, 0, 1, 32'hDDDD_0000, 0);
    step(0, 0, 1, 0, '0, 0);
    check("dis_active", bus.active_O, 0);
    check("dis_base", bus.base_addr_O, 32'hBBBB_0000);
    vs_pulse(); vs_pulse();
    step(0, 1, 1, 0, '0, 0);
    check("en_dis_off", bus.active_O, 0);

    // Frame counter wrap (CW reduced here so the bench stays short).
    step(0, 1, 0, 0, '0, 0);
    for (int i = 0; i < (1 << CW); i++) vs_pulse();
    check("fcnt_wrap", bus.frame_cnt_O, 0);

    // Reset in the middle of a pending swap.
    step(0, 0, 0, 1, 32'hEEEE_0000, 0);
    step(1, 0, 0, 0, '0, 0);
    check("rst_pending", bus.swap_pending_O, 0);
    check("rst_base", bus.base_addr_O, 0);

    // Randomized traffic.
    vs = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) vs = ~vs;
      step($urandom_range(0, 999) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0, $urandom, vs);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fb_swap_ctrl.md
Name: fb_swap_ctrl

Overview:
Consumes the single-cycle command pulses produced from user slave registers (enable, disable, buffer-swap) and applies them to the HDMI output path at frame-safe instants. A swap request latches a new frame-buffer base address into a shadow register. The new address becomes the active scan-out address only at the next vsync leading edge. The block also provides frame-start pulses, a frame counter and a dropped-swap counter for software status.

Parameters:
AW, 32, width of frame-buffer base address
CW, 16, width of frame counter
DW, 8, width of dropped-swap counter
VSYNC_POL, 1, active level of vsync_I (1 = active-high)
RESET_ADDR, 0, base_addr_O value after reset

Ports:
clk  input  1  pixel/bus clock; all logic on posedge
rst  input  1  synchronous active-high reset
enable_I  input  1  one-cycle pulse: start output
disable_I  input  1  one-cycle pulse: stop output
swap_I  input  1  one-cycle pulse: request buffer swap
addr_I  input  AW  new base address, sampled in the cycle swap_I=1
vsync_I  input  1  vsync from video timing, same clock domain
base_addr_O  output  AW  active scan-out base address
active_O  output  1  1 while state is RUN or PENDING
swap_pending_O  output  1  1 while state is PENDING
swap_done_O  output  1  one-cycle pulse when base_addr_O updates
frame_start_O  output  1  one-cycle pulse per vsync leading edge while active
frame_cnt_O  output  CW  frames since enable, wraps modulo 2^CW
drop_cnt_O  output  DW  swaps overwritten before being applied, saturating

Behaviour:
- Reset (rst=1 at a clk edge): state=OFF, base_addr_O=RESET_ADDR, shadow=0, all pulse outputs 0, frame_cnt_O=0, drop_cnt_O=0, vsync history register=inactive. rst has priority over every input.
- Vsync edge detection: a registered copy of vsync_I is held. vs_edge = (vsync_I==VSYNC_POL) && (prev!=VSYNC_POL), evaluated combinationally in cycle N. All effects of the edge appear on outputs at the clk edge ending cycle N (1-cycle latency).
- Every output is registered; pulse outputs are high for exactly one cycle.
- State OFF:
  - enable_I -> RUN; frame_cnt_O cleared to 0.
  - swap_I -> base_addr_O<=addr_I, swap_done_O=1 next cycle; state stays OFF (not scanning, so safe to apply immediately).
  - vs_edge ignored; frame_start_O=0.
- State RUN:
  - swap_I -> shadow<=addr_I; state -> PENDING.
  - vs_edge -> frame_start_O=1, frame_cnt_O+1.
- State PENDING:
  - vs_edge -> base_addr_O<=shadow, swap_done_O=1, frame_start_O=1, frame_cnt_O+1, state -> RUN.
  - swap_I without vs_edge -> shadow<=addr_I (last request wins), drop_cnt_O+1 (saturates at 2^DW-1).
  - swap_I together with vs_edge -> the old shadow is applied; the new addr_I goes to shadow; state stays PENDING; drop_cnt_O unchanged.
- disable_I in any state -> OFF next cycle; any pending shadow is discarded (not applied); no swap_done_O. base_addr_O is kept.
- enable_I and disable_I in the same cycle -> disable wins.
- enable_I while already RUN or PENDING -> no effect.
- disable_I together with swap_I in RUN or PENDING -> go to OFF; the swap is dropped and drop_cnt_O+1.
- frame_cnt_O wraps from 2^CW-1 to 0.
- active_O and swap_pending_O are decoded from the state register.

Decomposition:
- Shared package hdmi_out_pkg holds the state encodings (OFF=2'd0, RUN=2'd1, PENDING=2'd2) and the default base-address constant. Other hdmi_out blocks reuse them.
- One natural sub-module: vsync_edge_det (parameter POL). It owns the history register and the vs_edge output, and is reusable for hsync/DE.
- The FSM and counters stay in fb_swap_ctrl.

Test Plan:
1. Reset, then swap_I with addr_I=0x1000_0000 in OFF -> next cycle base_addr_O=0x1000_0000, swap_done_O=1 for 1 cycle, active_O=0.
2. enable_I, then swap_I addr=0x2000_0000, then vsync rise 10 cycles later -> swap_pending_O=1 for 10 cycles; the cycle after the edge, base_addr_O=0x2000_0000, swap_done_O=1, frame_start_O=1, frame_cnt_O=1, swap_pending_O=0.
3. In RUN, three swap_I (A, B, C) before one vsync edge -> base_addr_O=C after the edge, drop_cnt_O=2. Then repeat 300 drops -> drop_cnt_O holds at 255.
4. swap_I in the same cycle as vs_edge while PENDING(shadow=A), addr_I=B -> base_addr_O=A, state stays PENDING. The next edge applies B.
5. PENDING with shadow=D, then disable_I -> active_O=0 next cycle, base_addr_O unchanged, no swap_done_O; later vsync edges give frame_start_O=0. Also: enable_I and disable_I together -> stays OFF.
6. Run 65536 vsync edges with CW=16 -> frame_cnt_O wraps to 0. rst asserted mid-PENDING -> all outputs return to reset values the next cycle.
